// File: rtl/dsp_rr_sched.sv
// Round-robin front end for one shared 2-cycle (a+b)*c core. Issue is
// credit-gated against the result FIFO so a non-stallable core never drops a result.
module dsp_rr_sched #(
    parameter int DW        = 8,
    parameter int NUM_REQ   = 4,
    parameter int RES_DEPTH = 4,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    input  logic [NUM_REQ*DW-1:0] req_c,
    output logic [DW-1:0]         dsp_a,
    output logic [DW-1:0]         dsp_b,
    output logic [DW-1:0]         dsp_c,
    input  logic [2*DW-1:0]       dsp_m_tdata,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DW-1:0]       res_data,
    output logic [IDW-1:0]        res_id,
    output logic [1:0]            inflight
);

    // Handshake: a requester transfers in a cycle where req_valid[i] and
    // req_ready[i] are both high; the result side pops when res_valid & res_ready.
    localparam int AW = $clog2(RES_DEPTH);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  sel;
    logic            any_valid;
    logic            can_issue;
    logic            issue;
    logic            st0_v;
    logic            st1_v;
    logic [IDW-1:0]  st0_id;
    logic [IDW-1:0]  st1_id;
    logic [2*DW-1:0] data_mem [RES_DEPTH];
    logic [IDW-1:0]  id_mem   [RES_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;

    assign inflight = {1'b0, st0_v} + {1'b0, st1_v};
    // Registered occupancy only: a same-cycle pop never lends a credit.
    assign can_issue = rst && ((int'(count) + int'(inflight)) < RES_DEPTH);
    assign issue     = any_valid && can_issue;

    always_comb begin
        int idx;
        sel       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                sel       = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        dsp_a     = '0;
        dsp_b     = '0;
        dsp_c     = '0;
        if (issue) begin
            req_ready[sel] = 1'b1;
            dsp_a          = req_a[int'(sel)*DW +: DW];
            dsp_b          = req_b[int'(sel)*DW +: DW];
            dsp_c          = req_c[int'(sel)*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            st0_v  <= 1'b0;
            st0_id <= '0;
            st1_v  <= 1'b0;
            st1_id <= '0;
        end else begin
            if (issue) begin
                ptr <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
            end
            st0_v  <= issue;
            st0_id <= issue ? sel : '0;
            st1_v  <= st0_v;
            st1_id <= st0_id;
        end
    end

    assign push      = st1_v;
    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= dsp_m_tdata;
            id_mem[wr_ptr]   <= st1_id;
        end
    end

    assign res_data = res_valid ? data_mem[rd_ptr] : '0;
    assign res_id   = res_valid ? id_mem[rd_ptr]   : '0;

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (int'(count) == RES_DEPTH)));

endmodule
